reprogram_loader: RTL and testbench
===================================

// Module: reprogram_loader
// PURPOSE
//  Parametrised successor of the UART reprogram path. Consumes a byte stream already in the
//  clk_50mhz domain, parses framed packets (sync, base address, word count, payload, checksum)
//  and packs little-endian bytes into DATA_BYTES-wide words. Words are buffered in a FIFO and
//  issued on a valid/ready memory write port at base+index. Adds explicit start address,
//  backpressure, inter-byte timeout and error reporting.
// PARAMETERS
//  ADDR_W       23          write address width; header carries ceil(ADDR_W/8) address bytes
//  DATA_BYTES   4           bytes per word (1..8); wr_data width = 8*DATA_BYTES
//  LEN_W        16          word-count field width (2 header bytes, LE; upper bits unused)
//  FIFO_DEPTH   4           word FIFO depth (power of 2, >=2)
//  TIMEOUT_CYC  5_000_000   idle clocks mid-packet before abort (100 ms at 50 MHz)
//  SYNC_BYTE    8'hA5       packet start marker
// PORTS
//  clk_50mhz   in   1             system clock
//  rstn        in   1             reset, asynchronous, active-low
//  in_valid    in   1             byte valid
//  in_data     in   8             byte
//  in_ready    out  1             byte accepted when in_valid & in_ready
//  wr_valid    out  1             memory write request
//  wr_ready    in   1             memory accepts write when wr_valid & wr_ready
//  wr_addr     out  ADDR_W        word address
//  wr_data     out  8*DATA_BYTES  word, first received byte in [7:0]
//  busy        out  1             state != IDLE or FIFO non-empty
//  done        out  1             1-cycle pulse: packet complete, all words written, no error
//  err         out  1             sticky error flag, cleared on next accepted SYNC_BYTE
//  err_code    out  2             01 timeout, 10 checksum mismatch, 00 none
//  xorc        out  8             running XOR of bytes after sync in current packet
// BEHAVIOUR
//  - Reset: in_ready=1, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, err_code=0,
//    xorc=0, FIFO empty, state IDLE, counters 0. Reset mid-packet discards all buffered words.
//  - States: IDLE -> HDR_ADDR -> HDR_LEN -> PAYLOAD -> CHK -> DRAIN -> IDLE.
//  - IDLE: non-sync bytes consumed and ignored; SYNC_BYTE -> HDR_ADDR, clears err/err_code/xorc.
//  - HDR_ADDR: ceil(ADDR_W/8) bytes LE into base; bits above ADDR_W dropped.
//  - HDR_LEN: 2 bytes LE into count; count==0 skips PAYLOAD (goes to CHK).
//  - PAYLOAD: bytes shifted into assembler; on byte DATA_BYTES push word into FIFO with addr
//    base+index (mod 2^ADDR_W, wraps silently); after count words -> CHK.
//  - Every accepted byte after sync (incl. checksum byte) XORs into xorc; valid packet gives 0.
//  - in_ready = 0 in PAYLOAD while FIFO full, and in DRAIN; 1 otherwise.
//  - FIFO push/pop in same cycle allowed (occupancy unchanged). Pop when wr_valid & wr_ready.
//  - wr_valid/wr_addr/wr_data driven from FIFO head; latency last payload byte -> wr_valid
//    = 1 cycle when FIFO empty. wr_addr/wr_data held stable while wr_valid & !wr_ready.
//  - DRAIN: wait FIFO empty; then done=1 for one cycle if err==0, return IDLE.
//  - Timeout: counter resets on each accepted byte; in any state except IDLE/DRAIN, TIMEOUT_CYC
//    clocks without a byte -> err=1, err_code=01, partial word discarded, go DRAIN (FIFO
//    contents still written), no done. Counter does not run while in_ready=0.
//  - SYNC_BYTE inside a packet is plain data (no resync).
// CONFIGURATION
//  REPROG_CHECKSUM_EN defined: CHK expects one byte; after it xorc!=0 -> err=1, err_code=10,
//  no done (words already written stay written). Not defined: no checksum byte, CHK passes
//  straight to DRAIN; xorc still computed; err_code 10 never produced.
// TESTING
//  1 REPROG_CHECKSUM_EN, A5 00 01 00 | 02 00 | 11 22 33 44 55 66 77 88 | chk=xor -> writes
//    (0x000100,0x44332211),(0x000101,0x88776655), done 1 pulse, err=0, xorc=00.
//  2 Same packet, chk byte ^ 0x01 -> both words written, err=1, err_code=10, no done.
//  3 wr_ready held 0 for 20 cycles, count=8 -> FIFO fills (4 words), in_ready drops, no
//    byte lost; release -> 8 writes in order, addresses contiguous.
//  4 Base 7F FF FF, count=2 -> addresses 0x7FFFFF then 0x000000.
//  5 Stop after 2 payload bytes, TIMEOUT_CYC=100 -> err_code=01 at 100 idle cycles, no write
//    of partial word, busy falls, next A5 clears err.
//  6 rstn low mid-PAYLOAD with 2 words queued -> wr_valid=0 immediately, FIFO empty, IDLE;
//    garbage bytes 00 FF before A5 ignored on next packet.

Source files
------------

// File: rtl/reprogram_loader_if.sv
// reprogram_loader_if: byte-stream input and word-write output handshakes.
// Slave modport is the loader side, master is the producer/memory side.
interface reprogram_loader_if #(
    parameter int ADDR_W     = 23,
    parameter int DATA_BYTES = 4
);
    logic                    in_valid;
    logic [7:0]              in_data;
    logic                    in_ready;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [ADDR_W-1:0]       wr_addr;
    logic [8*DATA_BYTES-1:0] wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );
endinterface

// File: rtl/reprogram_loader.sv
// reprogram_loader: framed byte stream -> LE words -> FIFO -> memory writes.
// Define REPROG_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module reprogram_loader #(
    parameter int         ADDR_W      = 23,
    parameter int         DATA_BYTES  = 4,
    parameter int         LEN_W       = 16,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         TIMEOUT_CYC = 5_000_000,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic              clk_50mhz,
    input  logic              rstn,
    reprogram_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        xorc
);
    localparam int AB  = (ADDR_W + 7) / 8;
    localparam int DW  = 8 * DATA_BYTES;
    localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, HDR_ADDR, HDR_LEN, PAYLOAD, CHK, DRAIN
    } state_t;

`ifdef REPROG_CHECKSUM_EN
    localparam state_t POST_ST = CHK;
`else
    localparam state_t POST_ST = DRAIN;
`endif

    state_t          state_q;
    logic [8*AB-1:0] base_q;
    logic [7:0]      len_lo_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] widx_q;
    logic [2:0]      hcnt_q;
    logic [BCW-1:0]  bcnt_q;
    logic [DW-1:0]   asm_q;
    logic [TW-1:0]   tcnt_q;
    logic            done_q;
    logic            err_q;
    logic [1:0]      code_q;
    logic [7:0]      xorc_q;

    logic [ADDR_W-1:0] mem_a [FIFO_DEPTH];
    logic [DW-1:0]     mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wp_q;
    logic [PW-1:0]     rp_q;
    logic [PW:0]       cnt_q;

    logic              rdy;
    logic              full;
    logic              empty;
    logic              active;
    logic              accept;
    logic              tick;
    logic              tmo;
    logic              last_b;
    logic              push;
    logic              pop;
    logic [DW-1:0]     word_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [15:0]       len_d;
    logic [LEN_W-1:0]  widx_nx;

    assign full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);

    always_comb begin
        unique case (state_q)
            PAYLOAD: rdy = !full;
            DRAIN:   rdy = 1'b0;
            default: rdy = 1'b1;
        endcase
    end

    assign active  = state_q inside {HDR_ADDR, HDR_LEN, PAYLOAD, CHK};
    assign accept  = bus.in_valid && rdy;
    // Idle time only counts while we are actually able to take a byte.
    assign tick    = active && rdy && !accept;
    assign tmo     = tick && (tcnt_q == TW'(TIMEOUT_CYC - 1));
    assign last_b  = (bcnt_q == BCW'(DATA_BYTES - 1));
    assign push    = accept && (state_q == PAYLOAD) && last_b;
    assign pop     = !empty && bus.wr_ready;
    assign len_d   = {bus.in_data, len_lo_q};
    assign widx_nx = widx_q + LEN_W'(1);
    assign waddr_d = base_q[ADDR_W-1:0] + ADDR_W'(widx_q);

    always_comb begin
        word_d = asm_q;
        word_d[8*bcnt_q +: 8] = bus.in_data;
    end

    generate
        if (8 * AB > ADDR_W) begin : g_pad
            logic unused_base;
            assign unused_base = ^base_q[8*AB-1:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk_50mhz or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_lo_q <= '0;
            len_q    <= '0;
            widx_q   <= '0;
            hcnt_q   <= '0;
            bcnt_q   <= '0;
            asm_q    <= '0;
            tcnt_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
            xorc_q   <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (accept || !active) tcnt_q <= '0;
            else if (tick)         tcnt_q <= tcnt_q + TW'(1);
            if (accept && state_q != IDLE) xorc_q <= xorc_q ^ bus.in_data;
            if (tmo) begin
                state_q <= DRAIN;
                err_q   <= 1'b1;
                code_q  <= 2'b01;
                bcnt_q  <= '0;
            end else begin
                unique case (state_q)
                    IDLE: if (accept && bus.in_data == SYNC_BYTE) begin
                        state_q <= HDR_ADDR;
                        err_q   <= 1'b0;
                        code_q  <= 2'b00;
                        xorc_q  <= 8'h00;
                        hcnt_q  <= '0;
                    end
                    HDR_ADDR: if (accept) begin
                        base_q[8*hcnt_q +: 8] <= bus.in_data;
                        if (hcnt_q == 3'(AB - 1)) begin
                            hcnt_q  <= '0;
                            state_q <= HDR_LEN;
                        end else begin
                            hcnt_q <= hcnt_q + 3'd1;
                        end
                    end
                    HDR_LEN: if (accept) begin
                        if (hcnt_q == 3'd0) begin
                            len_lo_q <= bus.in_data;
                            hcnt_q   <= 3'd1;
                        end else begin
                            len_q   <= len_d[LEN_W-1:0];
                            widx_q  <= '0;
                            bcnt_q  <= '0;
                            state_q <= (len_d[LEN_W-1:0] == '0) ? POST_ST : PAYLOAD;
                        end
                    end
                    PAYLOAD: if (accept) begin
                        if (last_b) begin
                            bcnt_q <= '0;
                            widx_q <= widx_nx;
                            if (widx_nx == len_q) state_q <= POST_ST;
                        end else begin
                            asm_q  <= word_d;
                            bcnt_q <= bcnt_q + BCW'(1);
                        end
                    end
`ifdef REPROG_CHECKSUM_EN
                    CHK: if (accept) begin
                        state_q <= DRAIN;
                        if ((xorc_q ^ bus.in_data) != 8'h00) begin
                            err_q  <= 1'b1;
                            code_q <= 2'b10;
                        end
                    end
`endif
                    DRAIN: if (empty) begin
                        done_q  <= !err_q;
                        state_q <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge rstn) begin
        if (!rstn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + PW'(1);
            if (pop)  rp_q <= rp_q + PW'(1);
            if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
            else if (pop && !push) cnt_q <= cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (push) begin
            mem_a[wp_q] <= waddr_d;
            mem_d[wp_q] <= word_d;
        end
    end

    assign bus.in_ready = rdy;
    assign bus.wr_valid = !empty;
    assign bus.wr_addr  = empty ? '0 : mem_a[rp_q];
    assign bus.wr_data  = empty ? '0 : mem_d[rp_q];
    assign busy         = (state_q != IDLE) || !empty;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = code_q;
    assign xorc         = xorc_q;
endmodule

// File: tb/tb_reprogram_loader.sv
// tb_reprogram_loader: directed bench for reprogram_loader.
// Table of single-word packets plus hand sequences for multi-cycle cases.
module tb_reprogram_loader;
    localparam int AW  = 23;
    localparam int DB  = 4;
    localparam int TMO = 100;

    typedef struct {
        logic [23:0]   base_wire;
        logic [31:0]   data_wire;
        logic [AW-1:0] exp_addr;
        logic [31:0]   exp_data;
    } vec_t;

    vec_t vecs [4];

    logic       clk_50mhz = 1'b0;
    logic       rstn      = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] xorc;

    always #10 clk_50mhz = ~clk_50mhz;

    reprogram_loader_if #(.ADDR_W(AW), .DATA_BYTES(DB)) bus ();

    reprogram_loader #(
        .ADDR_W(AW), .DATA_BYTES(DB), .LEN_W(16), .FIFO_DEPTH(4),
        .TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_50mhz(clk_50mhz),
        .rstn(rstn),
        .bus(bus),
        .busy(busy),
        .done(done),
        .err(err),
        .err_code(err_code),
        .xorc(xorc)
    );

    logic [AW-1:0] wa [$];
    logic [31:0]   wd [$];
    int            done_cnt = 0;

    always @(posedge clk_50mhz) begin
        if (bus.wr_valid && bus.wr_ready) begin
            wa.push_back(bus.wr_addr);
            wd.push_back(bus.wr_data);
        end
        if (done) done_cnt++;
    end

    int         checks = 0;
    int         errors = 0;
    int         sent   = 0;
    logic [7:0] tx [$];
    logic [7:0] px;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic r;
        int   n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        do begin
            r = bus.in_ready;
            @(negedge clk_50mhz);
            n++;
        end while (!r && n < 1000);
        if (r) sent++;
        else   chk("byte_accept", 64'(r), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_tx();
        while (tx.size() > 0) send(tx.pop_front());
    endtask

    task automatic put(input logic [7:0] b);
        tx.push_back(b);
        px = px ^ b;
    endtask

    task automatic hdr(input logic [23:0] bw, input logic [15:0] cnt);
        tx.push_back(8'hA5);
        px = 8'h00;
        put(bw[23:16]);
        put(bw[15:8]);
        put(bw[7:0]);
        put(cnt[7:0]);
        put(cnt[15:8]);
    endtask

    task automatic tail();
`ifdef REPROG_CHECKSUM_EN
        put(px);
`endif
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk_50mhz);
            n++;
        end
        if (busy) chk("idle_wait", 64'(busy), 64'd0);
        repeat (2) @(negedge clk_50mhz);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         n0;
        int         d0;
        logic [7:0] xexp;
        logic [7:0] b3 [32];
        logic [31:0] w;

        vecs[0] = '{24'h341200, 32'h11223344, 23'h001234, 32'h44332211};
        vecs[1] = '{24'hFFFFFF, 32'hA5A5A5A5, 23'h7FFFFF, 32'hA5A5A5A5};
        vecs[2] = '{24'h000080, 32'h00000000, 23'h000000, 32'h00000000};
        vecs[3] = '{24'h785634, 32'hDEADBEEF, 23'h345678, 32'hEFBEADDE};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.wr_ready = 1'b1;
        repeat (3) @(negedge clk_50mhz);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
        chk("rst_wr_addr",  64'(bus.wr_addr),  64'd0);
        chk("rst_wr_data",  64'(bus.wr_data),  64'd0);
        chk("rst_busy",     64'(busy),         64'd0);
        chk("rst_done",     64'(done),         64'd0);
        chk("rst_err",      64'(err),          64'd0);
        chk("rst_err_code", 64'(err_code),     64'd0);
        chk("rst_xorc",     64'(xorc),         64'd0);
        rstn = 1'b1;
        @(negedge clk_50mhz);

        for (int i = 0; i < 4; i++) begin
            n0 = wa.size();
            d0 = done_cnt;
            hdr(vecs[i].base_wire, 16'd1);
            for (int j = 3; j >= 0; j--) put(vecs[i].data_wire[8*j +: 8]);
            tail();
            xexp = px;
            send_tx();
            wait_idle();
            chk($sformatf("v%0d_nwr", i), 64'(wa.size() - n0), 64'd1);
            if (wa.size() > n0) begin
                chk($sformatf("v%0d_addr", i), 64'(wa[n0]), 64'(vecs[i].exp_addr));
                chk($sformatf("v%0d_data", i), 64'(wd[n0]), 64'(vecs[i].exp_data));
            end
            chk($sformatf("v%0d_done", i), 64'(done_cnt - d0), 64'd1);
            chk($sformatf("v%0d_err", i), 64'(err), 64'd0);
            chk($sformatf("v%0d_xorc", i), 64'(xorc), 64'(xexp));
        end

        // two-word packet, valid framing
        n0 = wa.size();
        d0 = done_cnt;
        hdr(24'h000100, 16'd2);
        for (int k = 1; k <= 8; k++) put(8'(k * 8'h11));
        tail();
        xexp = px;
        send_tx();
        wait_idle();
        chk("t1_nwr", 64'(wa.size() - n0), 64'd2);
        if (wa.size() >= n0 + 2) begin
            chk("t1_a0", 64'(wa[n0]),     64'h000100);
            chk("t1_d0", 64'(wd[n0]),     64'h44332211);
            chk("t1_a1", 64'(wa[n0 + 1]), 64'h000101);
            chk("t1_d1", 64'(wd[n0 + 1]), 64'h88776655);
        end
        chk("t1_done", 64'(done_cnt - d0), 64'd1);
        chk("t1_err",  64'(err),  64'd0);
        chk("t1_xorc", 64'(xorc), 64'(xexp));

`ifdef REPROG_CHECKSUM_EN
        // bad checksum: words still written, error instead of done
        n0 = wa.size();
        d0 = done_cnt;
        hdr(24'h000100, 16'd2);
        for (int k = 1; k <= 8; k++) put(8'(k * 8'h11));
        put(px ^ 8'h01);
        send_tx();
        wait_idle();
        chk("t2_nwr",  64'(wa.size() - n0), 64'd2);
        chk("t2_done", 64'(done_cnt - d0), 64'd0);
        chk("t2_err",  64'(err),      64'd1);
        chk("t2_code", 64'(err_code), 64'd2);
`endif

        // zero-length packet
        n0 = wa.size();
        d0 = done_cnt;
        hdr(24'h000000, 16'd0);
        tail();
        send_tx();
        wait_idle();
        chk("z_nwr",  64'(wa.size() - n0), 64'd0);
        chk("z_done", 64'(done_cnt - d0), 64'd1);
        chk("z_err",  64'(err), 64'd0);

        // backpressure: FIFO fills, input stalls, nothing lost
        n0 = wa.size();
        d0 = done_cnt;
        for (int k = 0; k < 32; k++) b3[k] = 8'(k * 7 + 3);
        hdr(24'h000200, 16'd8);
        for (int k = 0; k < 32; k++) put(b3[k]);
        tail();
        bus.wr_ready = 1'b0;
        sent = 0;
        fork
            send_tx();
            begin
                repeat (40) @(negedge clk_50mhz);
                chk("bp_sent",     64'(sent),          64'd22);
                chk("bp_in_ready", 64'(bus.in_ready),  64'd0);
                chk("bp_wr_valid", 64'(bus.wr_valid),  64'd1);
                chk("bp_hold_addr", 64'(bus.wr_addr),  64'h000200);
                chk("bp_hold_data", 64'(bus.wr_data),
                    64'({b3[3], b3[2], b3[1], b3[0]}));
                bus.wr_ready = 1'b1;
            end
        join
        wait_idle();
        chk("bp_nwr", 64'(wa.size() - n0), 64'd8);
        if (wa.size() >= n0 + 8) begin
            for (int j = 0; j < 8; j++) begin
                w = {b3[4*j+3], b3[4*j+2], b3[4*j+1], b3[4*j]};
                chk($sformatf("bp_a%0d", j), 64'(wa[n0 + j]), 64'(23'h000200 + 23'(j)));
                chk($sformatf("bp_d%0d", j), 64'(wd[n0 + j]), 64'(w));
            end
        end
        chk("bp_done", 64'(done_cnt - d0), 64'd1);

        // address wrap at 2^ADDR_W
        n0 = wa.size();
        hdr(24'hFFFF7F, 16'd2);
        for (int k = 1; k <= 8; k++) put(8'(k));
        tail();
        send_tx();
        wait_idle();
        chk("wrap_nwr", 64'(wa.size() - n0), 64'd2);
        if (wa.size() >= n0 + 2) begin
            chk("wrap_a0", 64'(wa[n0]),     64'h7FFFFF);
            chk("wrap_d0", 64'(wd[n0]),     64'h04030201);
            chk("wrap_a1", 64'(wa[n0 + 1]), 64'h000000);
            chk("wrap_d1", 64'(wd[n0 + 1]), 64'h08070605);
        end

        // timeout after a partial word
        n0 = wa.size();
        d0 = done_cnt;
        hdr(24'h100000, 16'd1);
        put(8'h12);
        put(8'h34);
        send_tx();
        repeat (TMO - 1) @(negedge clk_50mhz);
        chk("tmo_early_err", 64'(err), 64'd0);
        @(negedge clk_50mhz);
        chk("tmo_err",  64'(err),      64'd1);
        chk("tmo_code", 64'(err_code), 64'd1);
        wait_idle();
        chk("tmo_busy", 64'(busy), 64'd0);
        chk("tmo_nwr",  64'(wa.size() - n0), 64'd0);
        chk("tmo_done", 64'(done_cnt - d0), 64'd0);
        tx.push_back(8'hA5);
        send_tx();
        chk("sync_clr_err",  64'(err),      64'd0);
        chk("sync_clr_code", 64'(err_code), 64'd0);

        // reset mid-payload with two words queued
        bus.wr_ready = 1'b0;
        put(8'h00);
        put(8'h03);
        put(8'h00);
        put(8'h04);
        put(8'h00);
        for (int k = 0; k < 8; k++) put(8'(8'hC0 + k));
        send_tx();
        chk("pre_rst_valid", 64'(bus.wr_valid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(bus.wr_valid), 64'd0);
        chk("rst_mid_busy",  64'(busy),         64'd0);
        chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk_50mhz);
        rstn = 1'b1;
        bus.wr_ready = 1'b1;
        @(negedge clk_50mhz);
        n0 = wa.size();
        d0 = done_cnt;
        tx.push_back(8'h00);
        tx.push_back(8'hFF);
        hdr(24'h400000, 16'd1);
        put(8'hDE);
        put(8'hAD);
        put(8'hBE);
        put(8'hEF);
        tail();
        send_tx();
        wait_idle();
        chk("post_rst_nwr", 64'(wa.size() - n0), 64'd1);
        if (wa.size() > n0) begin
            chk("post_rst_addr", 64'(wa[n0]), 64'h000040);
            chk("post_rst_data", 64'(wd[n0]), 64'hEFBEADDE);
        end
        chk("post_rst_done", 64'(done_cnt - d0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
